ct_l2cache_dirty_array_param: RTL



---
 rtl/ct_l2cache_pkg.sv | 6 +
 rtl/ct_l2cache_dirty_array_param_if.sv | 26 ++
 rtl/ct_l2cache_dirty_sram.sv | 20 ++
 rtl/ct_l2cache_dirty_array_param.sv | 74 +++++++
 4 files changed

// File: rtl/ct_l2cache_pkg.sv
// ct_l2cache_pkg: shared FSM state encoding and legal read-latency constants for the L2 dirty array
package ct_l2cache_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;
  localparam int RD_LAT_1 = 1;
  localparam int RD_LAT_2 = 2;
endpackage

// File: rtl/ct_l2cache_dirty_array_param_if.sv
// ct_l2cache_dirty_array_param_if: request/read/init bundle; master drives init_req, req_*; slave drives req_rdy, rd_vld, rd_dout, init_done
interface ct_l2cache_dirty_array_param_if #(
  parameter int WAYS = 16,
  parameter int WAY_BITS = 9,
  parameter int TAG_INDEX_WIDTH = 9
);
  localparam int DW = WAYS * WAY_BITS;
  logic init_req;
  logic req_vld;
  logic req_rdy;
  logic req_wr;
  logic [TAG_INDEX_WIDTH-1:0] req_idx;
  logic [WAYS-1:0] req_way_en;
  logic [DW-1:0] req_din;
  logic rd_vld;
  logic [DW-1:0] rd_dout;
  logic init_done;
  modport master (
    output init_req, req_vld, req_wr, req_idx, req_way_en, req_din,
    input req_rdy, rd_vld, rd_dout, init_done
  );
  modport slave (
    input init_req, req_vld, req_wr, req_idx, req_way_en, req_din,
    output req_rdy, rd_vld, rd_dout, init_done
  );
endinterface

// File: rtl/ct_l2cache_dirty_sram.sv
// ct_l2cache_dirty_sram: single-port SRAM, 1-cycle read; A addr, CEN/GWEN/WEN active-low chip/global-write/bit-write enables, D in, Q out (holds between reads)
module ct_l2cache_dirty_sram #(
  parameter int DEPTH = 512,
  parameter int DW = 144,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          CEN,
  input  logic          GWEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  input  logic [DW-1:0] WEN,
  output logic [DW-1:0] Q
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge CLK) begin
    if (!CEN && !GWEN) r_mem[A] <= (r_mem[A] & WEN) | (D & ~WEN);
    if (!CEN && GWEN) Q <= r_mem[A];
  end
endmodule

// File: rtl/ct_l2cache_dirty_array_param.sv
// ct_l2cache_dirty_array_param: way-masked dirty/state array with clear sweep; dirty_clk, dirty_rst (async high), io_bus request/read/init bundle
module ct_l2cache_dirty_array_param
  import ct_l2cache_pkg::*;
#(
  parameter int WAYS = 16,
  parameter int WAY_BITS = 9,
  parameter int TAG_INDEX_WIDTH = 9,
  parameter int RD_LAT = RD_LAT_1
) (
  input logic dirty_clk,
  input logic dirty_rst,
  ct_l2cache_dirty_array_param_if.slave io_bus
);
  localparam int DW = WAYS * WAY_BITS;
  localparam int DEPTH = 1 << TAG_INDEX_WIDTH;
  state_t r_state, w_state_nxt;
  logic [TAG_INDEX_WIDTH-1:0] r_cnt, w_cnt_nxt, w_a;
  logic [RD_LAT-1:0] r_pipe;
  logic [DW-1:0] r_hold, w_q, w_mask, w_d, w_wen;
  logic w_init, w_acc, w_rd_acc, w_inflight, w_cen, w_gwen;
  for (genvar w = 0; w < WAYS; w++) begin : g_mask
    assign w_mask[w*WAY_BITS +: WAY_BITS] = {WAY_BITS{io_bus.req_way_en[w]}};
  end
  assign w_init = r_state == ST_INIT;
  assign io_bus.init_done = r_state == ST_RUN;
  assign io_bus.req_rdy = io_bus.init_done && !io_bus.init_req;
  assign w_acc = io_bus.req_vld && io_bus.req_rdy;
  assign w_rd_acc = w_acc && !io_bus.req_wr;
  // with a 2-cycle read, a read in the macro-output stage has not yet reached rd_dout
  assign w_inflight = RD_LAT == RD_LAT_2 && r_pipe[0];
  // an all-zero way mask leaves the macro idle rather than doing an empty write
  assign w_cen = !(w_init || w_rd_acc || (w_acc && |io_bus.req_way_en));
  assign w_gwen = !(w_init || (w_acc && io_bus.req_wr));
  assign w_a = w_init ? r_cnt : io_bus.req_idx;
  assign w_d = w_init ? '0 : io_bus.req_din;
  assign w_wen = w_init ? '0 : ~w_mask;
  assign io_bus.rd_vld = r_pipe[RD_LAT-1];
  assign io_bus.rd_dout = (RD_LAT == RD_LAT_1 && r_pipe[0]) ? w_q : r_hold;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = '0;
    case (r_state)
      ST_INIT: begin
        w_cnt_nxt = io_bus.init_req ? '0 : r_cnt + 1'b1;
        w_state_nxt = (!io_bus.init_req && &r_cnt) ? ST_RUN : ST_INIT;
      end
      ST_RUN: w_state_nxt = !io_bus.init_req ? ST_RUN : w_inflight ? ST_DRAIN : ST_INIT;
      ST_DRAIN: w_state_nxt = w_inflight ? ST_DRAIN : ST_INIT;
      default: w_state_nxt = ST_INIT;
    endcase
  end
  always_ff @(posedge dirty_clk or posedge dirty_rst) begin
    if (dirty_rst) begin
      r_state <= ST_INIT;
      r_cnt <= '0;
      r_pipe <= '0;
      r_hold <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_pipe <= RD_LAT'({r_pipe, w_rd_acc});
      if (r_pipe[0]) r_hold <= w_q;
    end
  end
  ct_l2cache_dirty_sram #(.DEPTH(DEPTH), .DW(DW), .AW(TAG_INDEX_WIDTH)) u_sram (
    .CLK(dirty_clk),
    .CEN(w_cen),
    .GWEN(w_gwen),
    .A(w_a),
    .D(w_d),
    .WEN(w_wen),
    .Q(w_q)
  );
endmodule
